// File: rtl/memory_game_pkg.sv
// Shared constants and types for the memory game's playback and response-checking sides.
package memory_game_pkg;

  localparam int unsigned SYM_W           = 2;
  localparam int unsigned NUM_KEYS        = 4;
  localparam int unsigned MAX_SEQ_LEN     = 16;
  localparam int unsigned PATTERN_W       = SYM_W * MAX_SEQ_LEN;
  localparam int unsigned LEN_W           = 5;
  localparam int unsigned TIMER_W         = 32;
  localparam int unsigned DEFAULT_TIMEOUT = 150000000;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StRelease,
    StDone
  } resp_state_e;

  // Symbol 0 lives in the top two bits so the word reads in playback order.
  function automatic logic [SYM_W-1:0] symbol_at(input logic [PATTERN_W-1:0] pattern,
                                                 input logic [3:0] idx);
    logic [PATTERN_W-1:0] shifted;
    shifted = pattern << {idx, 1'b0};
    return shifted[PATTERN_W-1 -: SYM_W];
  endfunction

endpackage

// File: rtl/response_checker_if.sv
// Controller-side bundle for the response checker: level load, response window, keys, results.
interface response_checker_if;
  import memory_game_pkg::*;

  logic                 load_level;
  logic [PATTERN_W-1:0] pattern;
  logic [LEN_W-1:0]     level_len;
  logic                 start_response;
  logic [NUM_KEYS-1:0]  key_n;
  logic                 done_response;
  logic                 pass;
  logic                 fail;
  logic [LEN_W-1:0]     progress;

  modport master (
    output load_level, pattern, level_len, start_response, key_n,
    input  done_response, pass, fail, progress
  );

  modport slave (
    input  load_level, pattern, level_len, start_response, key_n,
    output done_response, pass, fail, progress
  );

endinterface

// File: rtl/key_sync.sv
// Two-flop synchronizer for the active-low buttons plus press-event detection
// (all-released followed by at least one key down).
module key_sync
  import memory_game_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] keys,
  output logic                all_released,
  output logic                press
);

  logic [NUM_KEYS-1:0] meta_q;
  logic [NUM_KEYS-1:0] sync_q;
  logic                released_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q     <= '1;
      sync_q     <= '1;
      released_q <= 1'b1;
    end else begin
      meta_q     <= key_n;
      sync_q     <= meta_q;
      released_q <= &sync_q;
    end
  end

  assign keys         = ~sync_q;
  assign all_released = &sync_q;
  assign press        = released_q & ~all_released;

endmodule

// File: rtl/response_checker.sv
// Checks the player's key presses against a stored pattern, with a per-press timeout.
module response_checker
  import memory_game_pkg::*;
#(
  parameter int unsigned MAX_LEN        = MAX_SEQ_LEN,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input logic                clk,
  input logic                reset,
  response_checker_if.slave  bus
);

  localparam logic [TIMER_W-1:0] TimerReload = TIMER_W'(TIMEOUT_CYCLES - 1);

  resp_state_e          state_q, state_d;
  logic [PATTERN_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     progress_q, progress_d;
  logic                 pass_q, pass_d;
  logic                 fail_q, fail_d;
  logic                 done_q, done_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;

  logic [NUM_KEYS-1:0]  keys;
  logic                 all_released;
  logic                 press;
  logic [SYM_W-1:0]     key_idx;
  logic                 press_ok;
  logic [LEN_W-1:0]     progress_inc;

  key_sync u_key_sync (
    .clk          (clk),
    .reset        (reset),
    .key_n        (bus.key_n),
    .keys         (keys),
    .all_released (all_released),
    .press        (press)
  );

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len == '0) return LEN_W'(1);
    if ({{(32-LEN_W){1'b0}}, len} > MAX_LEN) return LEN_W'(MAX_LEN);
    return len;
  endfunction

  always_comb begin
    key_idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keys[i]) key_idx = SYM_W'(i);
    end
  end

  assign press_ok     = $onehot(keys) && (key_idx == symbol_at(pattern_q, progress_q[3:0]));
  assign progress_inc = progress_q + LEN_W'(1);

  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    len_d      = len_q;
    progress_d = progress_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    done_d     = 1'b0;
    timer_d    = timer_q;

    if (bus.load_level) begin
      // A new level wins over anything in flight, including a same-cycle press.
      pattern_d  = bus.pattern;
      len_d      = clamp_len(bus.level_len);
      progress_d = '0;
      pass_d     = 1'b0;
      fail_d     = 1'b0;
      timer_d    = TimerReload;
      state_d    = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          timer_d = TimerReload;
          if (bus.start_response) state_d = StArmed;
        end
        StArmed: begin
          if (!bus.start_response) begin
            state_d    = StIdle;
            pass_d     = 1'b0;
            fail_d     = 1'b0;
            progress_d = '0;
            timer_d    = TimerReload;
          end else if (press) begin
            if (press_ok) begin
              progress_d = progress_inc;
              if (progress_inc == len_q) begin
                pass_d  = 1'b1;
                done_d  = 1'b1;
                state_d = StDone;
              end else begin
                state_d = StRelease;
              end
            end else begin
              fail_d  = 1'b1;
              done_d  = 1'b1;
              state_d = StDone;
            end
          end else if (timer_q == '0) begin
            fail_d  = 1'b1;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        StRelease: begin
          if (!bus.start_response) begin
            state_d    = StIdle;
            pass_d     = 1'b0;
            fail_d     = 1'b0;
            progress_d = '0;
            timer_d    = TimerReload;
          end else if (all_released) begin
            state_d = StArmed;
            timer_d = TimerReload;
          end else if (timer_q == '0) begin
            fail_d  = 1'b1;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        StDone: begin
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pattern_q  <= '0;
      len_q      <= LEN_W'(1);
      progress_q <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      done_q     <= 1'b0;
      timer_q    <= TimerReload;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      len_q      <= len_d;
      progress_q <= progress_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      done_q     <= done_d;
      timer_q    <= timer_d;
    end
  end

  assign bus.done_response = done_q;
  assign bus.pass          = pass_q;
  assign bus.fail          = fail_q;
  assign bus.progress      = progress_q;

endmodule

// File: tb/tb_response_checker.sv
// Directed bench for response_checker: a table of single-press vectors plus
// hand-written multi-cycle sequences (full pass, wrong key, timeout, reset, load collision).
module tb_response_checker;
  import memory_game_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  response_checker_if bus ();

  response_checker #(
    .MAX_LEN        (16),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  always @(negedge clk) if (bus.done_response === 1'b1) done_cnt++;

  typedef struct {
    logic [31:0] pattern;
    logic [4:0]  len;
    logic [3:0]  keys;
    logic [4:0]  exp_prog;
    logic        exp_pass;
    logic        exp_fail;
    int          exp_done;
  } vec_t;

  vec_t vecs[8];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic load(input logic [31:0] pat, input logic [4:0] len);
    bus.load_level = 1'b1;
    bus.pattern    = pat;
    bus.level_len  = len;
    tick(1);
    bus.load_level = 1'b0;
  endtask

  task automatic begin_attempt(input logic [31:0] pat, input logic [4:0] len);
    bus.start_response = 1'b0;
    bus.key_n          = 4'hF;
    tick(3);
    load(pat, len);
    bus.start_response = 1'b1;
    tick(1);
  endtask

  // Press lands in progress/fail three edges later: two sync flops plus the register.
  task automatic hold(input logic [3:0] mask);
    bus.key_n = ~mask;
    tick(3);
  endtask

  task automatic release_all();
    bus.key_n = 4'hF;
    tick(3);
  endtask

  initial begin
    int d0;

    vecs[0] = '{32'h1B000000, 5'd4,  4'b0001, 5'd1, 1'b0, 1'b0, 0};
    vecs[1] = '{32'h1B000000, 5'd4,  4'b0010, 5'd0, 1'b0, 1'b1, 1};
    vecs[2] = '{32'h1B000000, 5'd4,  4'b0011, 5'd0, 1'b0, 1'b1, 1};
    vecs[3] = '{32'h1B000000, 5'd0,  4'b0001, 5'd1, 1'b1, 1'b0, 1};
    vecs[4] = '{32'hC0000000, 5'd1,  4'b1000, 5'd1, 1'b1, 1'b0, 1};
    vecs[5] = '{32'hC0000000, 5'd1,  4'b0100, 5'd0, 1'b0, 1'b1, 1};
    vecs[6] = '{32'h40000000, 5'd31, 4'b0010, 5'd1, 1'b0, 1'b0, 0};
    vecs[7] = '{32'h80000000, 5'd2,  4'b1100, 5'd0, 1'b0, 1'b1, 1};

    bus.load_level     = 1'b0;
    bus.pattern        = '0;
    bus.level_len      = '0;
    bus.start_response = 1'b0;
    bus.key_n          = 4'hF;
    tick(2);
    reset = 1'b0;
    tick(1);

    check("reset_progress", 32'(bus.progress), 0);
    check("reset_pass", 32'(bus.pass), 0);
    check("reset_fail", 32'(bus.fail), 0);
    check("reset_done", 32'(bus.done_response), 0);

    for (int i = 0; i < 8; i++) begin
      begin_attempt(vecs[i].pattern, vecs[i].len);
      d0 = done_cnt;
      hold(vecs[i].keys);
      release_all();
      check($sformatf("vec%0d_progress", i), 32'(bus.progress), 32'(vecs[i].exp_prog));
      check($sformatf("vec%0d_pass", i), 32'(bus.pass), 32'(vecs[i].exp_pass));
      check($sformatf("vec%0d_fail", i), 32'(bus.fail), 32'(vecs[i].exp_fail));
      check($sformatf("vec%0d_done", i), 32'(done_cnt - d0), 32'(vecs[i].exp_done));
    end

    // Full four-symbol pass.
    begin_attempt(32'h1B000000, 5'd4);
    d0 = done_cnt;
    for (int k = 0; k < 4; k++) begin
      hold(4'(1 << k));
      check($sformatf("full_progress%0d", k), 32'(bus.progress), 32'(k + 1));
      if (k == 3) check("full_done_pulse", 32'(bus.done_response), 1);
      release_all();
    end
    check("full_pass", 32'(bus.pass), 1);
    hold(4'b0001);
    release_all();
    check("full_hold_progress", 32'(bus.progress), 4);
    check("full_hold_pass", 32'(bus.pass), 1);
    check("full_done_once", 32'(done_cnt - d0), 1);

    // Correct then wrong key.
    begin_attempt(32'h1B000000, 5'd4);
    hold(4'b0001);
    release_all();
    hold(4'b0100);
    check("wrong_done_pulse", 32'(bus.done_response), 1);
    check("wrong_fail", 32'(bus.fail), 1);
    check("wrong_progress", 32'(bus.progress), 1);
    tick(1);
    check("wrong_done_clear", 32'(bus.done_response), 0);
    release_all();

    // Idle timeout in ARMED.
    begin_attempt(32'h1B000000, 5'd4);
    tick(99);
    check("timeout_early", 32'(bus.fail), 0);
    tick(1);
    check("timeout_fail", 32'(bus.fail), 1);
    check("timeout_done", 32'(bus.done_response), 1);

    // Key held through RELEASE past the timeout.
    begin_attempt(32'h1B000000, 5'd4);
    hold(4'b0001);
    tick(120);
    check("rel_timeout_fail", 32'(bus.fail), 1);
    check("rel_timeout_progress", 32'(bus.progress), 1);
    release_all();

    // Reset while in RELEASE with progress 2.
    begin_attempt(32'h1B000000, 5'd4);
    hold(4'b0001);
    release_all();
    hold(4'b0010);
    check("prereset_progress", 32'(bus.progress), 2);
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    check("reset_async_progress", 32'(bus.progress), 0);
    tick(2);
    reset = 1'b0;
    release_all();
    tick(3);
    check("reset_no_done", 32'(done_cnt - d0), 0);
    check("reset_fail_clear", 32'(bus.fail), 0);

    // load_level coinciding with the press event.
    begin_attempt(32'h1B000000, 5'd4);
    bus.key_n = 4'b1110;
    tick(2);
    load(32'h1B000000, 5'd4);
    check("collide_progress", 32'(bus.progress), 0);
    tick(4);
    check("collide_held_ignored", 32'(bus.progress), 0);
    release_all();
    hold(4'b0001);
    check("collide_after", 32'(bus.progress), 1);
    release_all();

    // start_response dropping mid-attempt aborts silently.
    begin_attempt(32'h1B000000, 5'd4);
    d0 = done_cnt;
    hold(4'b0001);
    bus.start_response = 1'b0;
    tick(1);
    check("abort_progress", 32'(bus.progress), 0);
    release_all();
    check("abort_no_done", 32'(done_cnt - d0), 0);

    // Length 31 clamps to 16.
    begin_attempt(32'h00000000, 5'd31);
    for (int k = 0; k < 15; k++) begin
      hold(4'b0001);
      release_all();
    end
    check("clamp_no_pass15", 32'(bus.pass), 0);
    hold(4'b0001);
    check("clamp_pass16", 32'(bus.pass), 1);
    check("clamp_progress16", 32'(bus.progress), 16);
    release_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
